// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode constants and FSM state encoding shared by the alu_seq block
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_AND  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_DIV  = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_MUL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ============================================================================
// alu_iter_unit : one-bit-per-cycle shift-add multiplier; restoring divider
//                 added when ALU_DIV_EN is defined. WIDTH iterations per op.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res,
  output logic             res_carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic             carry_n;
`ifdef ALU_DIV_EN
  logic             div_q;
  logic [WIDTH:0]   trial;
`endif

  // hi:lo is the running product (mul) or remainder:quotient (div)
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, opd & {WIDTH{lo[0]}}};
    nxt_hi  = sum[WIDTH:1];
    nxt_lo  = {sum[0], lo[WIDTH-1:1]};
    carry_n = |sum[WIDTH:1];
`ifdef ALU_DIV_EN
    trial   = {hi, lo[WIDTH-1]} - {1'b0, opd};
    if (div_q) begin
      nxt_hi  = trial[WIDTH] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : trial[WIDTH-1:0];
      nxt_lo  = {lo[WIDTH-2:0], ~trial[WIDTH]};
      carry_n = (opd == '0);
    end
`endif
    res       = nxt_lo;
    res_carry = carry_n;
    last      = busy && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      opd  <= '0;
`ifdef ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi   <= '0;
`ifdef ALU_DIV_EN
      div_q <= is_div;
      lo    <= is_div ? op_a : op_b;
      opd   <= is_div ? op_b : op_a;
`else
      lo  <= op_b;
      opd <= op_a;
`endif
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + CNT_ONE;
      if (cnt == CNT_LAST) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : registered ALU with valid/ready handshake, zero/carry flags and an
//           iterative multiplier. Define ALU_DIV_EN to enable opcode 011 DIV.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Control,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  state_t           state;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry;
  logic [WIDTH:0]   ext;
  logic             is_iter;
  logic             iter_start;
  logic             iter_last;
  logic [WIDTH-1:0] iter_res;
  logic             iter_carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef ALU_DIV_EN
  assign is_iter = (Control == ALU_MUL) || (Control == ALU_DIV);
`else
  assign is_iter = (Control == ALU_MUL);
`endif
  assign iter_start = (state == IDLE) && in_valid && is_iter;

  // Single-cycle ops; reserved opcodes fall through to result 0, carry 0
  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    ext      = '0;
    case (Control)
      ALU_LOAD: sc_res = SrcB;
      ALU_AND:  sc_res = SrcA & SrcB;
      ALU_OR:   sc_res = SrcA | SrcB;
      ALU_ADD: begin
        ext      = {1'b0, SrcA} + {1'b0, SrcB};
        sc_res   = ext[WIDTH-1:0];
        sc_carry = ext[WIDTH];
      end
      ALU_SUB: begin
        ext      = {1'b0, SrcA} - {1'b0, SrcB};
        sc_res   = ext[WIDTH-1:0];
        sc_carry = ext[WIDTH];
      end
      default: ;
    endcase
  end

  alu_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (iter_start),
`ifdef ALU_DIV_EN
    .is_div   (Control == ALU_DIV),
`endif
    .op_a     (SrcA),
    .op_b     (SrcB),
    .last     (iter_last),
    .res      (iter_res),
    .res_carry(iter_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_iter) begin
              state <= EXEC;
            end else begin
              state  <= DONE;
              result <= sc_res;
              zero   <= (sc_res == '0);
              carry  <= sc_carry;
            end
          end
        end
        EXEC: begin
          // iter_res is the value the final iteration produces on this edge
          if (iter_last) begin
            state  <= DONE;
            result <= iter_res;
            zero   <= (iter_res == '0);
            carry  <= iter_carry;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed self-checking bench for alu_seq at WIDTH = 8
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   Control = 3'b000;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Control  (Control),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  // Present one operation for a single accept edge, then scramble the inputs
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Control  = op;
    SrcA     = a;
    SrcB     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA     = W'($urandom);
    SrcB     = W'($urandom);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, result, zero, carry} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%0d z=%b c=%b expected ov=0 ir=1 res=0 z=0 c=0",
               out_valid, in_ready, result, zero, carry);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    issue(3'b101, 8'd200, 8'd100);
    n_checks++;
    if ({out_valid, in_ready, result, zero, carry} !== {1'b1, 1'b0, 8'd44, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL add_200_100: got ov=%b ir=%b res=%0d z=%b c=%b expected ov=1 ir=0 res=44 z=0 c=1",
               out_valid, in_ready, result, zero, carry);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'd44}) begin
      n_fail++;
      $display("FAIL add_consume: got ov=%b ir=%b res=%0d expected ov=0 ir=1 res=44",
               out_valid, in_ready, result);
    end
  endtask

  task automatic test_single_ops();
    logic [2:0] ops [8] = '{3'b110, 3'b110, 3'b001, 3'b010, 3'b000, 3'b100, 3'b101, 3'b110};
    logic [7:0] as  [8] = '{8'd7, 8'd3, 8'd1, 8'd1, 8'd0, 8'd77, 8'd0, 8'd9};
    logic [7:0] bs  [8] = '{8'd3, 8'd7, 8'd1, 8'd3, 8'h5A, 8'd12, 8'd0, 8'd9};
    logic [7:0] ers [8] = '{8'd4, 8'd252, 8'd1, 8'd3, 8'h5A, 8'd0, 8'd0, 8'd0};
    logic       ecs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ezs [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      n_checks++;
      if ({out_valid, result, zero, carry} !== {1'b1, ers[i], ezs[i], ecs[i]}) begin
        n_fail++;
        $display("FAIL single_op_%0d (op=%b %0d,%0d): got ov=%b res=%0d z=%b c=%b expected ov=1 res=%0d z=%b c=%b",
                 i, ops[i], as[i], bs[i], out_valid, result, zero, carry, ers[i], ezs[i], ecs[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    logic [7:0] as  [4] = '{8'd1, 8'd16, 8'd15, 8'd255};
    logic [7:0] bs  [4] = '{8'd3, 8'd16, 8'd15, 8'd255};
    logic [7:0] ers [4] = '{8'd3, 8'd0, 8'd225, 8'd1};
    logic       ecs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       ezs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int early;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(3'b111, as[i], bs[i]);
      early = 0;
      for (int k = 0; k < 7; k++) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
        @(posedge clk); #1;
      end
      if (out_valid !== 1'b0 || in_ready !== 1'b0) early++;
      n_checks++;
      if (early != 0) begin
        n_fail++;
        $display("FAIL mul_busy_%0d: got %0d cycles with ov/ir high expected 0", i, early);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, result, zero, carry} !== {1'b1, ers[i], ezs[i], ecs[i]}) begin
        n_fail++;
        $display("FAIL mul_%0dx%0d: got ov=%b res=%0d z=%b c=%b expected ov=1 res=%0d z=%b c=%b",
                 as[i], bs[i], out_valid, result, zero, carry, ers[i], ezs[i], ecs[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    issue(3'b101, 8'd1, 8'd1);
    Control  = 3'b101;
    SrcA     = 8'd9;
    SrcB     = 8'd9;
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if ({out_valid, in_ready, result, zero, carry} !== {1'b1, 1'b0, 8'd2, 1'b0, 1'b0}) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got %0d unstable cycles expected 0 (res=%0d ov=%b)",
               bad, result, out_valid);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 8'd2}) begin
      n_fail++;
      $display("FAIL backpressure_release: got ov=%b ir=%b res=%0d expected ov=0 ir=1 res=2",
               out_valid, in_ready, result);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, result} !== {1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL backpressure_ignored_input: got ov=%b res=%0d expected ov=0 res=2",
               out_valid, result);
    end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    issue(3'b111, 8'd15, 8'd15);
    repeat (2) begin @(posedge clk); #1; end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, result, zero, carry} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got ov=%b ir=%b res=%0d z=%b c=%b expected ov=0 ir=1 res=0 z=0 c=0",
               out_valid, in_ready, result, zero, carry);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    n_checks++;
    if ({out_valid, result} !== {1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_discard: got ov=%b res=%0d expected ov=0 res=0", out_valid, result);
    end
    issue(3'b101, 8'd2, 8'd2);
    n_checks++;
    if ({out_valid, result, zero, carry} !== {1'b1, 8'd4, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_after_reset: got ov=%b res=%0d z=%b c=%b expected ov=1 res=4 z=0 c=0",
               out_valid, result, zero, carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_opcode_011();
`ifdef ALU_DIV_EN
    logic [7:0] as  [3] = '{8'd7, 8'd9, 8'd200};
    logic [7:0] bs  [3] = '{8'd3, 8'd0, 8'd7};
    logic [7:0] ers [3] = '{8'd2, 8'd255, 8'd28};
    logic       ecs [3] = '{1'b0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(3'b011, as[i], bs[i]);
      repeat (7) begin @(posedge clk); #1; end
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL div_early_%0d: got ov=%b expected ov=0", i, out_valid);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, result, zero, carry} !== {1'b1, ers[i], 1'b0, ecs[i]}) begin
        n_fail++;
        $display("FAIL div_%0d_by_%0d: got ov=%b res=%0d z=%b c=%b expected ov=1 res=%0d z=0 c=%b",
                 as[i], bs[i], out_valid, result, zero, carry, ers[i], ecs[i]);
      end
      @(posedge clk); #1;
    end
`else
    out_ready = 1'b1;
    issue(3'b011, 8'd7, 8'd3);
    n_checks++;
    if ({out_valid, result, zero, carry} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reserved_011: got ov=%b res=%0d z=%b c=%b expected ov=1 res=0 z=1 c=0",
               out_valid, result, zero, carry);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_back_to_back();
    int bad;
    out_ready = 1'b1;
    Control   = 3'b101;
    SrcA      = 8'd5;
    SrcB      = 8'd6;
    in_valid  = 1'b1;
    bad = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'(k % 2) || in_ready !== 1'(1 - (k % 2))) bad++;
      if ((k % 2) == 1 && result !== 8'd11) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_ops();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_opcode_011();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
